// File: rtl/inst_slot_rr_scheduler.sv
// Round-robin grant scheduler for the inst_0..inst_N-1 slot array (IDLE/GRANT/RELEASE).
// Optional grant watchdog enabled by defining INST_SLOT_GRANT_TIMEOUT_EN.
module inst_slot_rr_scheduler #(
  parameter int NUM_REQ  = 10,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << IDX_W) < NUM_REQ || MAX_HOLD < 2) begin : g_bad_cfg
    $error("inst_slot_rr_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   gnt_idx_n;
  logic [IDX_W-1:0]   last_idx, last_idx_n;
  logic               timeout_n;
  logic               hold_hit;
  logic               found;
  logic [IDX_W-1:0]   sel;
  logic               owner_done;
  logic               owner_req;
  logic               released;

`ifdef INST_SLOT_GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  logic [CNT_W-1:0] hold_cnt;

  // Counter is zero in IDLE/RELEASE, so it reads 0 on the first GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst || state != GRANT) hold_cnt <= '0;
    else                       hold_cnt <= hold_cnt + 1'b1;
  end

  assign hold_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_hit = 1'b0;
`endif

  assign owner_done = |(done & gnt);
  assign owner_req  = |(req & gnt);
  assign released   = owner_done || !owner_req;

  // Search from last_idx+1 upward, wrapping by compare so out-of-range indices never appear.
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    sel   = last_idx;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(last_idx) + 1 + i;
      if (idx > 32'(LAST_IDX)) idx = idx - NUM_REQ;
      cand = idx[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_idx_n  = gnt_idx;
    last_idx_n = last_idx;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          gnt_idx_n  = sel;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (released || hold_hit) begin
          gnt_n      = '0;
          last_idx_n = gnt_idx;
          state_n    = RELEASE;
          timeout_n  = !released;
        end
      end
      RELEASE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      gnt_idx       <= LAST_IDX;
      last_idx      <= LAST_IDX;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      gnt           <= gnt_n;
      gnt_idx       <= gnt_idx_n;
      last_idx      <= last_idx_n;
      timeout_pulse <= timeout_n;
    end
  end

  assign gnt_valid = |gnt;
  assign busy      = (state != IDLE);

endmodule

// File: doc/inst_slot_rr_scheduler.md
Name: inst_slot_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource among the NUM_REQ sibling instance slots (inst_0..inst_9) of a root-level wrapper.
- Each slot raises a request, receives an exclusive one-hot grant, and returns it with a done pulse.
- Sits beside the instance array in the root module and drives the per-slot enables.

Parameters:
- NUM_REQ, 10, number of requester slots (2..16).
- IDX_W, 4, width of the grant index; must satisfy 2^IDX_W >= NUM_REQ.
- MAX_HOLD, 64, maximum grant duration in cycles. Used only with the optional feature; must be >= 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-slot request level; bit i belongs to inst_i.
- done  input  NUM_REQ  per-slot release pulse; only the bit of the current owner is honoured.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_valid  output  1  high while any grant is held (OR of gnt).
- gnt_idx  output  IDX_W  index of the current owner; holds the last owner when gnt_valid is 0.
- busy  output  1  high in the GRANT and RELEASE states.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset, applied on a clk edge while rst=1:
  - gnt=0, gnt_valid=0, gnt_idx=NUM_REQ-1, busy=0, timeout_pulse=0.
  - Internal last_idx=NUM_REQ-1, so slot 0 has first priority.
  - State goes to IDLE.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is nonzero, select the first set bit searching from last_idx+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: gnt has the selected bit set, gnt_idx equals the selected index, state is GRANT.
  - Latency from req sampled to gnt visible is 1 cycle.
  - If req is zero, stay in IDLE.
- GRANT:
  - gnt is held stable.
  - Exit when done[gnt_idx]=1 or req[gnt_idx]=0. Dropping the request counts as an implicit release.
  - On exit: next cycle gnt=0, last_idx=gnt_idx, state is RELEASE.
  - done bits of non-owners are ignored with no side effect.
- RELEASE:
  - One dead cycle with no grant, to avoid back-to-back ownership overlap.
  - Unconditionally goes to IDLE.
  - The minimum spacing from done to the next gnt rising is 3 cycles: RELEASE, IDLE evaluation, then grant.
- Fairness: a continuously requesting slot waits for at most NUM_REQ-1 other grants.
- Simultaneous done and new requests: new requests are evaluated only in IDLE, against the updated last_idx.
- Out-of-range indices (NUM_REQ..2^IDX_W-1) are never generated. The wrap uses an explicit compare to NUM_REQ-1, not a power-of-two rollover.
- rst asserted mid-grant drops gnt on that same edge. No done is expected afterwards, and priority restarts at slot 0.
- gnt is at most one-hot at all times. A 0 vs 1 check on gnt is a required bench assertion.

Optional Feature:
- Macro: INST_SLOT_GRANT_TIMEOUT_EN.
- Enabled:
  - A hold counter of width clog2(MAX_HOLD)+1 clears on entry to GRANT and increments each cycle in GRANT.
  - When it reaches MAX_HOLD-1 without a release, the grant is revoked: next cycle gnt=0, state is RELEASE, last_idx=gnt_idx, timeout_pulse=1 for exactly one cycle.
  - A release on the same cycle as the timeout takes precedence, and timeout_pulse stays 0.
- Disabled:
  - No counter is built.
  - timeout_pulse is tied to 0.
  - A grant is held indefinitely.

Test Plan:
- Single requester: reset, then req=10'b0000001000 from cycle 2 → gnt=10'b0000001000 and gnt_idx=3 at cycle 3. Pulse done[3] at cycle 6 → gnt=0 at cycle 7, RELEASE.
- All requesting: req=10'h3FF held, each grant closed with done after 2 cycles → grant order 0,1,2,…,9,0. Consecutive grants are separated by 2 gnt=0 cycles.
- Foreign done: slot 5 owns the grant, done[2] and done[7] pulse → gnt unchanged and busy=1 until done[5].
- Implicit release: slot 4 owns the grant, req[4] drops with no done → gnt=0 next cycle. With req[4] and req[8] previously asserted, the next grant goes to slot 8.
- Reset mid-grant: slot 6 owns the grant, rst=1 for one cycle → gnt=0 after that edge. With req=10'h3FF, the next grant goes to slot 0.
- Timeout (macro defined, MAX_HOLD=8): slot 1 is granted and never releases → gnt drops after 8 grant cycles. timeout_pulse=1 for 1 cycle and the next grant goes to slot 2.
